// File: rtl/rng_pkg.sv
// Shared constants and types for the LFSR-based random number generators.
package rng_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } gen_state_e;

  localparam logic [31:0] DEFAULT_SEED = 32'h0000_ACE1;

  // Maximal-length Galois tap masks for the supported widths.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return 32'h0000_00B8;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with a seed load that never lets the register go all-zero.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = W'(DEFAULT_SEED)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] state_o
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    // A zero seed would lock the register; fall back to the default seed instead.
    if (load_i) begin
      state_d = (seed_i == '0) ? SEED : seed_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rng_lfsr.sv
// Request/valid random number source in [0, MAX] using bounded rejection sampling
// on the low OUT_W bits of a free-running LFSR.
module rng_lfsr
  import rng_pkg::*;
#(
  parameter int                MAX       = 15,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
  parameter int                MAX_TRIES = 4,
  localparam int               OUT_W     = $clog2(MAX + 1)
) (
  input  logic              posclk,
  input  logic              rst,
  input  logic              req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  num
);

  localparam int             TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  logic [LFSR_W-1:0] lfsr_state;
  logic [OUT_W-1:0]  cand;
  logic              cand_ok;
  logic              unused_hi;

  gen_state_e        fsm_q, fsm_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [OUT_W-1:0]  num_q, num_d;
  logic              valid_q, valid_d;

  lfsr_core #(
    .W    (LFSR_W),
    .SEED (SEED)
  ) u_core (
    .clk_i   (posclk),
    .rst_i   (rst),
    .load_i  (seed_load),
    .seed_i  (seed_in),
    .state_o (lfsr_state)
  );

  assign cand      = lfsr_state[OUT_W-1:0];
  assign cand_ok   = (32'(cand) <= 32'(MAX));
  assign unused_hi = ^lfsr_state[LFSR_W-1:OUT_W];

  always_comb begin
    fsm_d   = fsm_q;
    tries_d = tries_q;
    num_d   = num_q;
    valid_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (req) begin
          fsm_d   = GEN;
          tries_d = '0;
        end
      end
      GEN: begin
        if (cand_ok) begin
          num_d   = cand;
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end else if (tries_q == LAST_TRY) begin
          // Out-of-range candidate is below 2*(MAX+1), so one subtraction lands in range.
          num_d   = OUT_W'(32'(cand) - 32'(MAX + 1));
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge posclk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      tries_q <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      tries_q <= tries_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (fsm_q == GEN);
  assign valid = valid_q;
  assign num   = num_q;

endmodule

// File: tb/tb_rng_lfsr.sv
// Bench for rng_lfsr: three configurations share one stimulus stream and are
// compared against a per-cycle reference model derived from the generation rules.
module tb_rng_lfsr;

  logic        posclk = 1'b0;
  logic        rst, req, seed_load;
  logic [15:0] seed_in;

  logic       busy_a, valid_a, busy_b, valid_b, busy_c, valid_c;
  logic [3:0] num_a, num_b, num_c;

  always #5 posclk = ~posclk;

  // a: MAX=15 (no rejection), b: MAX=9 with 4 tries, c: MAX=9 with a single try
  rng_lfsr #(.MAX(15)) dut15 (
    .posclk(posclk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_a), .valid(valid_a), .num(num_a));
  rng_lfsr #(.MAX(9)) dut9 (
    .posclk(posclk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_b), .valid(valid_b), .num(num_b));
  rng_lfsr #(.MAX(9), .MAX_TRIES(1)) dut9t1 (
    .posclk(posclk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .busy(busy_c), .valid(valid_c), .num(num_c));

  logic       vld_w[3];
  logic       busy_w[3];
  logic [3:0] num_w[3];
  assign vld_w[0] = valid_a;  assign busy_w[0] = busy_a;  assign num_w[0] = num_a;
  assign vld_w[1] = valid_b;  assign busy_w[1] = busy_b;  assign num_w[1] = num_b;
  assign vld_w[2] = valid_c;  assign busy_w[2] = busy_c;  assign num_w[2] = num_c;

  int n_checks = 0;
  int n_err    = 0;

  int          m_max[3] = '{15, 9, 9};
  int          m_lim[3] = '{4, 4, 1};
  logic [15:0] m_state[3];
  bit          m_pend[3];
  int          m_used[3];
  int          m_num[3];
  bit          m_vld[3];
  int          m_acc[3];
  int          d_cnt[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s / 2) ^ (((s % 2) != 0) ? 16'hB400 : 16'h0000);
  endfunction

  // Advance the reference by one clock using the inputs as they stand before the edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int cand;
      cand = m_state[i] % 16;
      if (rst) begin
        m_state[i] = 16'hACE1;
        m_pend[i]  = 0;
        m_used[i]  = 0;
        m_num[i]   = 0;
        m_vld[i]   = 0;
      end else begin
        m_vld[i] = 0;
        if (m_pend[i]) begin
          m_used[i]++;
          if (cand <= m_max[i]) begin
            m_num[i] = cand;
            m_vld[i] = 1;
            m_pend[i] = 0;
          end else if (m_used[i] >= m_lim[i]) begin
            m_num[i] = cand - (m_max[i] + 1);
            m_vld[i] = 1;
            m_pend[i] = 0;
          end
        end else if (req) begin
          m_pend[i] = 1;
          m_used[i] = 0;
          m_acc[i]++;
        end
        m_state[i] = seed_load ? ((seed_in != 16'h0) ? seed_in : 16'hACE1)
                               : lfsr_next(m_state[i]);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge posclk);
    #1;
    for (int i = 0; i < 3; i++) if (vld_w[i] === 1'b1) d_cnt[i]++;
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("valid[%0d]", i), 32'(vld_w[i]), 32'(m_vld[i]));
      check($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_pend[i]));
      if (m_vld[i]) begin
        check($sformatf("num[%0d]", i), 32'(num_w[i]), 32'(m_num[i]));
        check($sformatf("range[%0d]", i), 32'(int'(num_w[i]) <= m_max[i]), 32'd1);
      end
    end
  endtask

  logic [15:0] seq[7] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27, 16'hB313};
  int cyc;

  initial begin
    rst = 1'b1; req = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; d_cnt[i] = 0; m_state[i] = 16'h0; m_pend[i] = 0;
      m_used[i] = 0; m_num[i] = 0; m_vld[i] = 0;
    end

    // Reset state, then a request in the first cycle after reset
    tick();
    check("rst_state", 32'(dut15.u_core.state_q), 32'hACE1);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_num", 32'(num_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    check("t1_busy", 32'(busy_a), 32'd1);
    check("t1_valid_early", 32'(valid_a), 32'd0);
    check("t1_state", 32'(dut15.u_core.state_q), 32'hE270);
    tick();
    check("t1_valid", 32'(valid_a), 32'd1);
    check("t1_num", 32'(num_a), 32'd0);
    check("t1_busy_done", 32'(busy_a), 32'd0);
    tick();
    check("t1_pulse", 32'(valid_a), 32'd0);

    // Free-running sequence after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("seq%0d", k), 32'(dut15.u_core.state_q), 32'(seq[k]));
      tick();
    end

    // Seeded rejection (b) and exhausted-tries fallback (c)
    rst = 1'b1;
    tick();
    rst = 1'b0; seed_load = 1'b1; seed_in = 16'h001F;
    tick();
    seed_load = 1'b0;
    check("t3_seed", 32'(dut9.u_core.state_q), 32'h001F);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t3_busy", 32'(busy_b), 32'd1);
    check("t3_state1", 32'(dut9.u_core.state_q), 32'hB40F);
    tick();
    check("t4_valid", 32'(valid_c), 32'd1);
    check("t4_num", 32'(num_c), 32'd5);
    check("t3_reject", 32'(valid_b), 32'd0);
    check("t3_still_busy", 32'(busy_b), 32'd1);
    check("t3_state2", 32'(dut9.u_core.state_q), 32'hEE07);
    tick();
    check("t3_valid", 32'(valid_b), 32'd1);
    check("t3_num", 32'(num_b), 32'd7);

    // Zero seed falls back to the default seed
    seed_load = 1'b1; seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("zero_seed15", 32'(dut15.u_core.state_q), 32'hACE1);
    check("zero_seed9", 32'(dut9.u_core.state_q), 32'hACE1);

    // Reset while dut9 is mid-generation
    seed_load = 1'b1; seed_in = 16'h001F;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("t6_busy_before", 32'(busy_b), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", 32'(busy_b), 32'd0);
    check("t6_valid", 32'(valid_b), 32'd0);
    check("t6_num", 32'(num_b), 32'd0);
    check("t6_num_c", 32'(num_c), 32'd0);
    check("t6_state", 32'(dut9.u_core.state_q), 32'hACE1);

    // Randomized run against the reference model
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; d_cnt[i] = 0;
    end
    cyc = 0;
    while (m_acc[1] < 10000 && cyc < 80000) begin
      req       = ($urandom_range(0, 9) < 7);
      seed_load = ($urandom_range(0, 49) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
      cyc++;
      check_cycle();
    end
    check("rand_reqs", 32'(m_acc[1]), 32'd10000);
    req = 1'b0; seed_load = 1'b0;
    repeat (8) begin
      tick();
      check_cycle();
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("valid_count[%0d]", i), 32'(d_cnt[i]), 32'(m_acc[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rng_lfsr.md
Name: rng_lfsr

Overview:
- Parametrised, synthesizable pseudo-random number generator for game logic such as target placement, spawn timing and dice.
- Replaces simulation-only random calls with a free-running Galois LFSR.
- Supports seeding, a request/valid handshake, and range-limited output in [0, MAX] using bounded rejection sampling.
- Sits beside the game FSM, which issues requests and consumes num on valid.

Parameters:
- MAX, 15: inclusive upper bound of output; must be at least 1.
- LFSR_W, 16: LFSR state width; supported values 8, 16, 32.
- SEED, 16'hACE1: reset and fallback seed, LFSR_W bits, must be nonzero.
- MAX_TRIES, 4: rejection attempts before fallback reduction; must be at least 1.
- OUT_W (localparam): $clog2(MAX+1).

Ports:
- posclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request one number; sampled only in IDLE.
- seed_load  in  1  load seed_in into the LFSR this edge.
- seed_in  in  LFSR_W  new seed value.
- busy  out  1  high while in GEN.
- valid  out  1  one-cycle pulse; num is new this cycle.
- num  out  OUT_W  random value in [0, MAX]; holds until the next valid.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= SEED; num <= 0; valid <= 0; busy <= 0; tries <= 0; FSM <= IDLE.
  - rst overrides everything, including mid-GEN.
- LFSR step, every cycle, free-running:
  - state <= (state >> 1) ^ (state[0] ? TAPS : 0).
  - TAPS: 8'hB8 for W=8, 16'hB400 for W=16, 32'h80200003 for W=32.
- Seed load:
  - seed_load=1 replaces the step that cycle: state <= seed_in, or SEED if seed_in==0, which prevents lock-up.
  - Allowed in any state. In GEN, sampling continues on the new state.
- Candidate: cand = state[OUT_W-1:0], taken from the current-cycle state.
- FSM IDLE:
  - busy=0.
  - req=1 -> GEN, tries <= 0.
- FSM GEN:
  - busy=1. req is ignored and not queued.
  - cand <= MAX: num <= cand, valid <= 1 next cycle, -> IDLE.
  - cand > MAX and tries < MAX_TRIES-1: tries++, stay in GEN.
  - cand > MAX and tries == MAX_TRIES-1: num <= cand - (MAX+1), valid <= 1, -> IDLE.
    - This fallback always lands in range because 2^OUT_W <= 2*(MAX+1).
- valid timing:
  - valid is a registered pulse, high exactly one cycle.
  - Minimum latency: req in cycle N -> valid in cycle N+2.
  - Maximum latency: N+1+MAX_TRIES.
- MAX = 2^OUT_W - 1: rejection never occurs; latency is always 2.
- req held high: a new request is accepted in the IDLE cycle coinciding with valid. Back-to-back throughput is one number per 2 cycles minimum.

Decomposition:
- Package rng_pkg holds:
  - the TAPS constant function indexed by LFSR_W;
  - the state enum {IDLE, GEN};
  - the default SEED constant.
- One natural sub-module: lfsr_core.
  - Contents: state register, step logic, seed mux with zero-guard.
  - Reusable by future multi-channel generators.
- rng_lfsr adds the FSM, the tries counter and the output registers.

Test Plan:
- Reset, then req in the first cycle (state=ACE1), MAX=15 -> GEN sees state E270; valid at N+2 with num=0; busy high for 1 cycle.
- Free-running check: after reset with no seed_load -> state sequence ACE1, E270, 7138, 389C, 1C4E, 0E27, B313.
- MAX=9:
  - Stimulus: seed_load seed_in=001F, then req the next cycle.
  - cand F is rejected (state B40F), then cand 7 is accepted (state EE07).
  - Expect num=7, valid at req+3.
- MAX=9, MAX_TRIES=1, same stimulus -> cand F rejected, tries exhausted -> num=5 (15-10), valid at req+2.
- seed_load with seed_in=0 -> next state=ACE1, not 0. Random run of 10k requests with MAX=9 -> no num > 9; no cycle with valid high for more than 1 cycle.
- rst asserted while busy in GEN -> next cycle busy=0, valid=0, num=0, state=ACE1. req during busy is ignored, and exactly one valid occurs per accepted req.
